// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the multicycle RV32I control path.
//   * opcode constants for the nine supported instruction classes
//   * state_t: controller FSM states
//   * ALU operation codes ({funct7[5], funct3} style encoding)
//   * register-file write-data source encodings (RFWDSrcMuxSel)
//   * ctrl_t: bundle of the single-bit / small control outputs
//   * exe_state_of(): maps an opcode to its first execute state
package rv32i_pkg;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  // Controller states
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    R_EXE  = 4'd2,
    I_EXE  = 4'd3,
    B_EXE  = 4'd4,
    LU_EXE = 4'd5,
    AU_EXE = 4'd6,
    J_EXE  = 4'd7,
    JL_EXE = 4'd8,
    S_EXE  = 4'd9,
    S_MEM  = 4'd10,
    L_EXE  = 4'd11,
    L_MEM  = 4'd12,
    L_WB   = 4'd13
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // funct3 of the right-shift group; only here does funct7[5] matter for I-type
  localparam logic [2:0] F3_SR = 3'b101;

  // Register-file write-data source select
  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_LOAD  = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_PCIMM = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  // Control outputs other than aluControl
  typedef struct packed {
    logic       ir_we;
    logic       pc_en;
    logic       rf_we;
    logic       alu_src;
    logic [2:0] rfwd_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       data_we;
    logic       data_req;
    logic       illegal;
  } ctrl_t;

  // First execute state for an opcode; FETCH marks an unrecognised opcode.
  function automatic state_t exe_state_of(input logic [6:0] op);
    state_t s;
    case (op)
      OP_R:    s = R_EXE;
      OP_I:    s = I_EXE;
      OP_B:    s = B_EXE;
      OP_LU:   s = LU_EXE;
      OP_AU:   s = AU_EXE;
      OP_J:    s = J_EXE;
      OP_JL:   s = JL_EXE;
      OP_S:    s = S_EXE;
      OP_L:    s = L_EXE;
      default: s = FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder -- derives the 4-bit ALU operation from the controller state
// and the funct fields of the current instruction.
//   state_i       : current controller state
//   funct3_i      : instr[14:12]
//   funct7_5_i    : instr[30]
//   alu_control_o : ALU operation select (ADD outside R/I/B execute)
module alu_decoder
  import rv32i_pkg::*;
(
  input  state_t     state_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (state_i)
      R_EXE: alu_control_o = {funct7_5_i, funct3_i};
      // For immediates, instr[30] is part of the immediate except for the
      // shift-right group, where it selects SRA vs SRL.
      I_EXE: alu_control_o = (funct3_i == F3_SR) ? {funct7_5_i, funct3_i}
                                                 : {1'b0, funct3_i};
      // Branch compare type is carried by funct3 alone.
      B_EXE: alu_control_o = {1'b0, funct3_i};
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM of a multicycle RV32I datapath.
//   clk, reset          : rising-edge clock, async active-high reset
//   instrCode[31:0]     : instruction-register contents
//   dataReady           : data memory finished the current access
//   irWe                : load instruction register (FETCH)
//   PCEn                : update PC / instruction retire pulse
//   regFileWe           : register-file write enable
//   aluControl[3:0]     : ALU operation
//   aluSrcMuxSel        : 0 = rs2, 1 = immediate
//   RFWDSrcMuxSel[2:0]  : register write-data source
//   branch, jal, jalr   : PC-select qualifiers
//   dataWe, dataReq     : store write / memory access request
//   illegalInstr        : unrecognised opcode seen in DECODE
//   dbg_state_o         : current FSM state, for observation only
//
// Handshake: in S_MEM / L_MEM dataReq stays high and the FSM holds until a
// cycle in which dataReady = 1; that cycle completes the access. dataReady is
// ignored in every other state.
module multicycle_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        dataReady,
  output logic        irWe,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        dataWe,
  output logic        dataReq,
  output logic        illegalInstr,
  output state_t      dbg_state_o
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic [3:0] alu_ctrl;
  state_t     decoded_exe;

  // Only opcode, funct3 and instr[30] steer the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign decoded_exe = exe_state_of(instrCode[6:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and control outputs
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.ir_we = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        if (decoded_exe == FETCH) begin
          // Unknown opcode: retire it as a no-op so the PC moves on.
          ctrl.illegal = 1'b1;
          ctrl.pc_en   = 1'b1;
          state_d      = FETCH;
        end else begin
          state_d = decoded_exe;
        end
      end
      R_EXE: begin
        ctrl.rf_we    = 1'b1;
        ctrl.alu_src  = 1'b0;
        ctrl.rfwd_src = RFWD_ALU;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      I_EXE: begin
        ctrl.rf_we    = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_src = RFWD_ALU;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      B_EXE: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_src = 1'b0;
        ctrl.pc_en   = 1'b1;
        state_d      = FETCH;
      end
      LU_EXE: begin
        ctrl.rf_we    = 1'b1;
        ctrl.rfwd_src = RFWD_IMM;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      AU_EXE: begin
        ctrl.rf_we    = 1'b1;
        ctrl.rfwd_src = RFWD_PCIMM;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      J_EXE: begin
        ctrl.rf_we    = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.rfwd_src = RFWD_PC4;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      JL_EXE: begin
        // jal qualifies the jump, jalr switches the target base to rs1.
        ctrl.rf_we    = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_src = RFWD_PC4;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      S_EXE: begin
        ctrl.alu_src = 1'b1;
        state_d      = S_MEM;
      end
      S_MEM: begin
        ctrl.alu_src  = 1'b1;
        ctrl.data_req = 1'b1;
        ctrl.data_we  = 1'b1;
        if (dataReady) begin
          // Store retires in the completing cycle; nothing to write back.
          ctrl.pc_en = 1'b1;
          state_d    = FETCH;
        end
      end
      L_EXE: begin
        ctrl.alu_src = 1'b1;
        state_d      = L_MEM;
      end
      L_MEM: begin
        ctrl.alu_src  = 1'b1;
        ctrl.data_req = 1'b1;
        if (dataReady) state_d = L_WB;
      end
      L_WB: begin
        ctrl.rf_we    = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.rfwd_src = RFWD_LOAD;
        ctrl.pc_en    = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .state_i       (state_q),
    .funct3_i      (instrCode[14:12]),
    .funct7_5_i    (instrCode[30]),
    .alu_control_o (alu_ctrl)
  );

  // Reset silences every output, including the irWe that FETCH would
  // otherwise drive while reset holds the state there.
  assign ctrl_out      = reset ? '0 : ctrl;
  assign aluControl    = reset ? ALU_ADD : alu_ctrl;

  assign irWe          = ctrl_out.ir_we;
  assign PCEn          = ctrl_out.pc_en;
  assign regFileWe     = ctrl_out.rf_we;
  assign aluSrcMuxSel  = ctrl_out.alu_src;
  assign RFWDSrcMuxSel = ctrl_out.rfwd_src;
  assign branch        = ctrl_out.branch;
  assign jal           = ctrl_out.jal;
  assign jalr          = ctrl_out.jalr;
  assign dataWe        = ctrl_out.data_we;
  assign dataReq       = ctrl_out.data_req;
  assign illegalInstr  = ctrl_out.illegal;
  assign dbg_state_o   = state_q;

endmodule
